// File: rtl/bch_bm_sched.sv
// Round-robin scheduler sharing one Berlekamp-Massey unit between several
// syndrome channels; completion is steered back to the issuing channel.
module bch_bm_sched #(
  parameter int pCH_NUM = 4,
  parameter int pCH_W   = 2,
  parameter int m       = 4,
  parameter int t2      = 6,
  parameter int pPTR_W  = 2
) (
  input  logic                        iclk,
  input  logic                        ireset_n,
  input  logic                        iclkena,
  input  logic [pCH_NUM-1:0]          isyn_val,
  input  logic [pCH_NUM*pPTR_W-1:0]   isyn_ptr,
  input  logic [pCH_NUM*t2*m-1:0]     isyndrome,
  output logic                        obm_syn_val,
  output logic [pPTR_W-1:0]           obm_syn_ptr,
  output logic [t2*m-1:0]             obm_syndrome,
  input  logic                        ibm_done,
  output logic [pCH_NUM-1:0]          oloc_val,
  output logic [pCH_W-1:0]            ochan,
  output logic                        obusy,
  output logic [pCH_NUM-1:0]          opending,
  output logic [pCH_NUM-1:0]          ooverflow,
  input  logic                        iclr_ovf
);

  localparam int SYN_W = t2 * m;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                      state, state_next;
  logic [pCH_W-1:0]            last_grant;
  logic [pCH_W-1:0]            sel;
  logic                        sel_found;
  logic                        issue;
  logic [pCH_NUM*SYN_W-1:0]    hold_syn;
  logic [pCH_NUM*pPTR_W-1:0]   hold_ptr;

  // Search last_grant+1, +2, ... with wrap; the first pending channel wins.
  always_comb begin : rr_pick
    logic [pCH_W:0] cand;
    cand      = '0;
    sel       = last_grant;
    sel_found = 1'b0;
    for (int k = 1; k <= pCH_NUM; k++) begin
      cand = {1'b0, last_grant} + (pCH_W+1)'(k);
      if (cand >= (pCH_W+1)'(pCH_NUM))
        cand = cand - (pCH_W+1)'(pCH_NUM);
      if (!sel_found && opending[cand[pCH_W-1:0]]) begin
        sel       = cand[pCH_W-1:0];
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      IDLE: if (sel_found) begin
        issue      = 1'b1;
        state_next = WAIT;
      end
      WAIT: if (ibm_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < pCH_NUM; gi++) begin : g_ch
      logic               granted;
      logic               pend;
      logic               ovf;
      logic [SYN_W-1:0]   syn;
      logic [pPTR_W-1:0]  ptr;

      assign granted = issue && (sel == pCH_W'(gi));

      // A granted channel may accept a new set on the same edge its old one leaves.
      always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
          pend <= 1'b0;
          ovf  <= 1'b0;
          syn  <= '0;
          ptr  <= '0;
        end else if (iclkena) begin
          if (isyn_val[gi] && (!pend || granted)) begin
            syn <= isyndrome[gi*SYN_W +: SYN_W];
            ptr <= isyn_ptr[gi*pPTR_W +: pPTR_W];
          end
          if (isyn_val[gi])
            pend <= 1'b1;
          else if (granted)
            pend <= 1'b0;
          if (isyn_val[gi] && pend && !granted)
            ovf <= 1'b1;
          else if (iclr_ovf)
            ovf <= 1'b0;
        end
      end

      assign opending[gi]                      = pend;
      assign ooverflow[gi]                     = ovf;
      assign hold_syn[gi*SYN_W +: SYN_W]       = syn;
      assign hold_ptr[gi*pPTR_W +: pPTR_W]     = ptr;
    end
  endgenerate

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state        <= IDLE;
      last_grant   <= pCH_W'(pCH_NUM-1);
      obm_syn_val  <= 1'b0;
      obm_syn_ptr  <= '0;
      obm_syndrome <= '0;
      oloc_val     <= '0;
      ochan        <= '0;
      obusy        <= 1'b0;
    end else if (iclkena) begin
      state       <= state_next;
      obm_syn_val <= issue;
      oloc_val    <= '0;
      if (issue) begin
        obm_syndrome <= hold_syn[sel*SYN_W +: SYN_W];
        obm_syn_ptr  <= hold_ptr[sel*pPTR_W +: pPTR_W];
        ochan        <= sel;
        last_grant   <= sel;
        obusy        <= 1'b1;
      end else if (state == WAIT && ibm_done) begin
        oloc_val <= pCH_NUM'(1) << ochan;
        obusy    <= 1'b0;
      end
    end
  end

endmodule

// File: doc/bch_bm_sched.md
Name: bch_bm_sched

Overview:
- Round-robin scheduler that shares one bch_berlekamp unit between pCH_NUM independent bch_syndrome_count channels.
- Each channel's syndrome set and buffer pointer are latched into a per-channel holding register.
- Holding registers are issued to the shared BM unit one at a time.
- The BM completion is routed back to the originating channel as a one-hot strobe, so each channel's Chien search instance can pick up the shared locator polynomial.

Parameters:
- pCH_NUM, 4, number of requesting syndrome channels (2..8)
- pCH_W, 2, channel index width, equal to clog2(pCH_NUM)
- m, 4, Galois field width; one syndrome is m bits
- t2, 6, number of syndromes per codeword (S1..St2)
- pPTR_W, 2, buffer pointer width carried with each syndrome set

Ports:
- iclk, in, 1, clock
- ireset_n, in, 1, asynchronous reset, active low
- iclkena, in, 1, clock enable; when low, all state and outputs hold
- isyn_val, in, pCH_NUM, per-channel syndrome-valid pulse
- isyn_ptr, in, pCH_NUM*pPTR_W, per-channel buffer pointer; channel c occupies bits [c*pPTR_W +: pPTR_W]
- isyndrome, in, pCH_NUM*t2*m, per-channel flattened syndromes; S1 is in the LSBs of each channel slice
- obm_syn_val, out, 1, one-cycle issue strobe to BM isyndrome_val
- obm_syn_ptr, out, pPTR_W, pointer of the issued set
- obm_syndrome, out, t2*m, syndromes of the issued set
- ibm_done, in, 1, BM oloc_poly_val
- oloc_val, out, pCH_NUM, one-hot completion strobe for the granted channel
- ochan, out, pCH_W, channel currently granted or last granted
- obusy, out, 1, high while a set is outstanding in BM
- opending, out, pCH_NUM, holding-register-full flags
- ooverflow, out, pCH_NUM, sticky per-channel drop flags
- iclr_ovf, in, 1, synchronous clear of ooverflow (requires iclkena)

Behaviour:
- Reset (ireset_n low, asynchronous):
  - all outputs 0; opending and ooverflow 0
  - holding registers cleared
  - state IDLE
  - round-robin pointer last_grant = pCH_NUM-1, so channel 0 has first priority
- Capture, at an edge where iclkena=1 and isyn_val[c]=1:
  - opending[c]=0: load isyn_ptr/isyndrome slice c into the holding register and set opending[c].
  - opending[c]=1 and c is not being granted at this edge: drop the new set, keep the old one, set ooverflow[c].
  - c is granted at this same edge: the old contents go to the output registers, the new set is stored, and opending[c] stays 1. No overflow.
- FSM, two states, IDLE and WAIT:
  - IDLE, |opending=1: select the first pending channel searching last_grant+1, +2, ... with modulo pCH_NUM wrap. At that edge:
    - load obm_syndrome and obm_syn_ptr from its holding register
    - obm_syn_val<=1; ochan<=c; last_grant<=c
    - clear opending[c] unless recaptured at the same edge
    - obusy<=1; go to WAIT
  - WAIT:
    - obm_syn_val<=0 after one cycle; obm_syndrome and obm_syn_ptr hold their values until the next issue.
    - On ibm_done=1: oloc_val<=one-hot(ochan) for exactly one cycle, obusy<=0, go to IDLE.
    - ibm_done is accepted from the first WAIT cycle, including the cycle where obm_syn_val is high.
  - IDLE with no pending channel: outputs idle; obm_syn_val=0, oloc_val=0.
- ibm_done while in IDLE is ignored; no oloc_val is produced.
- Latency:
  - isyn_val to obm_syn_val: 2 clocks minimum, with BM idle and no competitor.
  - ibm_done to oloc_val: 1 clock.
  - Back-to-back: a new issue can occur on the edge after oloc_val, so obm_syn_val has a minimum spacing of BM latency + 2 clocks.
- Fairness: with all channels continuously pending, grants rotate 0,1,2,3,0,...; no channel waits more than pCH_NUM-1 issues.
- iclkena=0 freezes everything: isyn_val and ibm_done pulses are not seen, and pulse outputs stay at their current level. Upstream and BM run on the same enable.
- Overflow:
  - ooverflow[c] is sticky until iclr_ovf=1.
  - If iclr_ovf and a new overflow event occur at the same edge, set wins.
- Reset mid-operation aborts any outstanding set. A later ibm_done from the BM unit is then ignored, because the FSM is in IDLE.

Test Plan:
- Single channel: reset, isyn_val[2]=1 with ptr=1 and syndromes 0x123456, BM done 5 cycles after issue. Required: obm_syn_val 2 clocks after capture with ptr=1 and data 0x123456; oloc_val=4'b0100 1 clock after ibm_done; obusy falls at the same time.
- Contention: isyn_val=4'b1111 in one cycle with distinct data per channel. Required: issue order 0,1,2,3, each carrying its own ptr and data; opending decrements 1111->1110->1100->1000->0000.
- Round-robin wrap: after a grant to channel 3, pend channels 0 and 3 together. Required: channel 0 is issued first.
- Overflow: isyn_val[1] twice while channel 1 is pending and BM is busy on channel 0. Required: first data is kept, ooverflow=4'b0010; then iclr_ovf clears it to 0.
- Grant/capture collision: isyn_val[0] on the same edge channel 0 is granted. Required: old data issued, opending[0] stays 1, no overflow, new data issued next.
- Reset in WAIT, then ibm_done pulse: required all outputs 0, no oloc_val; iclkena=0 for 3 cycles mid-WAIT stretches the sequence by exactly 3 clocks.
